// File: rtl/shared_bus_pkg.sv
// Shared bus arbiter package: FSM state encoding, default widths and the round-robin pick helper.
package shared_bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    localparam int DEF_MASTERS = 4;
    localparam int DEF_SLAVES  = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_SEL_W   = 2;
    localparam int MAX_MASTERS = 32;

    // First requester at or after ptr, wrapping modulo n; ptr itself when nothing is requesting.
    function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int i = MAX_MASTERS-1; i >= 0; i--) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (req[idx[4:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick with a rotating priority pointer that advances past the owner on completion.
module rr_arbiter
    import shared_bus_pkg::*;
#(
    parameter int N = DEF_MASTERS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 adv,
    input  logic [$clog2(N)-1:0] owner,
    output logic [$clog2(N)-1:0] pick
);

    localparam int IW = $clog2(N);

    logic [IW-1:0]          ptr;
    logic [MAX_MASTERS-1:0] req_ext;
    int                     pick_i;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick_i         = rr_pick(req_ext, int'(ptr), N);
        pick           = pick_i[IW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr <= '0;
        else if (adv) ptr <= (int'(owner) == N-1) ? '0 : owner + 1'b1;
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Shared bus upstream stage: round-robin master arbitration, one-hot slave decode, read capture and ack.
// Define SBA_ERR_EN to add m_err and suppress strobes for unmapped slave selects.
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_MASTERS,
    parameter int NUM_SLAVES  = DEF_SLAVES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DEF_SEL_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
`ifdef SBA_ERR_EN
    output logic                          m_err,
`endif
    output logic [NUM_SLAVES-1:0]         s_enable,
    output logic [ADDR_W-1:0]             s_address,
    output logic [DATA_W-1:0]             s_data_in,
    output logic                          s_write,
    output logic                          s_read,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_out
);

    localparam int IW = $clog2(NUM_MASTERS);

    state_t              state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       pick;
    logic [SEL_W-1:0]    sel;
    logic                wr;
    logic [ADDR_W-1:0]   pick_addr;
    logic [SEL_W-1:0]    pick_sel;
    logic                pick_mapped;
    logic                mapped;
    logic                strobe_ok;
    logic [DATA_W-1:0]   slave_rd;

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (m_req),
        .adv   (state == ACK),
        .owner (owner),
        .pick  (pick)
    );

    assign pick_addr   = m_addr[int'(pick)*ADDR_W +: ADDR_W];
    assign pick_sel    = pick_addr[ADDR_W-1 -: SEL_W];
    assign pick_mapped = int'(pick_sel) < NUM_SLAVES;
    assign mapped      = int'(sel) < NUM_SLAVES;
    assign slave_rd    = mapped ? s_data_out[int'(sel)*DATA_W +: DATA_W] : '0;
`ifdef SBA_ERR_EN
    assign strobe_ok   = pick_mapped;
`else
    assign strobe_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            sel       <= '0;
            wr        <= 1'b0;
            m_gnt     <= '0;
            m_ack     <= '0;
            m_rdata   <= '0;
            s_enable  <= '0;
            s_address <= '0;
            s_data_in <= '0;
            s_write   <= 1'b0;
            s_read    <= 1'b0;
`ifdef SBA_ERR_EN
            m_err     <= 1'b0;
`endif
        end else begin
            // Strobes and ack are single-cycle pulses; only the states below raise them.
            s_enable <= '0;
            s_write  <= 1'b0;
            s_read   <= 1'b0;
            m_ack    <= '0;
`ifdef SBA_ERR_EN
            m_err    <= 1'b0;
`endif
            case (state)
                IDLE: if (|m_req) begin
                    owner       <= pick;
                    m_gnt       <= '0;
                    m_gnt[pick] <= 1'b1;
                    sel         <= pick_sel;
                    wr          <= m_write[pick];
                    s_address   <= pick_addr;
                    s_data_in   <= m_wdata[int'(pick)*DATA_W +: DATA_W];
                    for (int j = 0; j < NUM_SLAVES; j++)
                        s_enable[j] <= pick_mapped && (int'(pick_sel) == j);
                    s_write     <= m_write[pick] & strobe_ok;
                    s_read      <= ~m_write[pick] & strobe_ok;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (wr) begin
                        m_ack[owner] <= 1'b1;
`ifdef SBA_ERR_EN
                        m_err        <= ~mapped;
`endif
                        state        <= ACK;
                    end else begin
                        state        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    m_rdata      <= slave_rd;
                    m_ack[owner] <= 1'b1;
`ifdef SBA_ERR_EN
                    m_err        <= ~mapped;
`endif
                    state        <= ACK;
                end
                ACK: begin
                    m_gnt     <= '0;
                    s_address <= '0;
                    s_data_in <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: read, write, reset mid-transaction, fairness and unmapped select.
module tb_shared_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    localparam logic [3:0][7:0] SV = {8'h96, 8'hC3, 8'hA5, 8'h5A};

    logic [3:0]       m_req, m_write, m_gnt, m_ack;
    logic [31:0]      m_addr, m_wdata, s_data_out;
    logic [7:0]       m_rdata, s_address, s_data_in;
    logic [3:0]       s_enable;
    logic             s_write, s_read;
    logic [3:0][7:0]  sdout, wr_mem;

    logic [3:0]       m_req3, m_write3, m_gnt3, m_ack3;
    logic [31:0]      m_addr3, m_wdata3;
    logic [7:0]       m_rdata3, s_address3, s_data_in3;
    logic [2:0]       s_enable3;
    logic             s_write3, s_read3;
    logic [23:0]      s_data_out3;
`ifdef SBA_ERR_EN
    logic             m_err, m_err3;
`endif

    int checks = 0;
    int errors = 0;

    assign s_data_out  = sdout;
    assign s_data_out3 = 24'h332211;

    shared_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack), .m_rdata(m_rdata),
`ifdef SBA_ERR_EN
        .m_err(m_err),
`endif
        .s_enable(s_enable), .s_address(s_address), .s_data_in(s_data_in),
        .s_write(s_write), .s_read(s_read), .s_data_out(s_data_out)
    );

    shared_bus_arbiter #(.NUM_SLAVES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .m_req(m_req3), .m_write(m_write3), .m_addr(m_addr3),
        .m_wdata(m_wdata3), .m_gnt(m_gnt3), .m_ack(m_ack3), .m_rdata(m_rdata3),
`ifdef SBA_ERR_EN
        .m_err(m_err3),
`endif
        .s_enable(s_enable3), .s_address(s_address3), .s_data_in(s_data_in3),
        .s_write(s_write3), .s_read(s_read3), .s_data_out(s_data_out3)
    );

    // Registered slaves: read data appears the edge after enable&read.
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (s_enable[j] && s_read)  sdout[j]  <= SV[j];
            if (s_enable[j] && s_write) wr_mem[j] <= s_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int eo;
        bit got;
        rst_n = 1'b1; m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0;
        m_req3 = '0; m_write3 = '0; m_addr3 = '0; m_wdata3 = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_gnt", m_gnt, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_en", s_enable, 0);
        chk("rst_strobes", {s_read, s_write}, 0);
        chk("rst_addr", s_address, 0);
        chk("rst_rdata", m_rdata, 0);
        @(negedge clk) rst_n = 1'b1;

        // Single read by master 0 from slave 1, address changed after grant
        m_addr[7:0] = 8'h42; m_req = 4'b0001;
        tick();
        chk("rd_gnt", m_gnt, 4'b0001);
        chk("rd_en", s_enable, 4'b0010);
        chk("rd_strobes", {s_read, s_write}, 2'b10);
        chk("rd_addr_issue", s_address, 8'h42);
        m_addr[7:0] = 8'hFF;
        tick();
        chk("rd_en_capture", s_enable, 0);
        chk("rd_ack_early", m_ack, 0);
        chk("rd_addr_capture", s_address, 8'h42);
        tick();
        chk("rd_ack", m_ack, 4'b0001);
        chk("rd_data", m_rdata, 8'hA5);
        chk("rd_addr_ack", s_address, 8'h42);
        m_req = '0;
        tick();
        chk("rd_idle_gnt", m_gnt, 0);
        chk("rd_idle_ack", m_ack, 0);
        chk("rd_idle_addr", s_address, 0);
        chk("rd_hold", m_rdata, 8'hA5);

        // Write by master 2 to slave 3
        m_req = 4'b0100; m_write = 4'b0100; m_addr[23:16] = 8'hC1; m_wdata[23:16] = 8'h3C;
        tick();
        chk("wr_gnt", m_gnt, 4'b0100);
        chk("wr_en", s_enable, 4'b1000);
        chk("wr_strobes", {s_read, s_write}, 2'b01);
        chk("wr_data_in", s_data_in, 8'h3C);
        tick();
        chk("wr_ack", m_ack, 4'b0100);
        chk("wr_strobe_off", s_write, 0);
        chk("wr_slave", wr_mem[3], 8'h3C);
        chk("wr_rdata_kept", m_rdata, 8'hA5);
        m_req = '0; m_write = '0;
        tick();

        // Reset during CAPTURE; pointer (now 3) must return to 0
        m_req = 4'b1000; m_addr[31:24] = 8'h40;
        tick();
        chk("mr_gnt", m_gnt, 4'b1000);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_gnt0", m_gnt, 0);
        chk("mr_addr0", s_address, 0);
        m_req = '0;
        tick();
        tick();
        chk("mr_noack", m_ack, 0);
        @(negedge clk) rst_n = 1'b1;
        m_req = 4'b1001; m_addr[7:0] = 8'h00; m_addr[31:24] = 8'hC0;
        tick();
        chk("mr_regrant", m_gnt, 4'b0001);
        tick();
        tick();
        chk("mr_ack", m_ack, 4'b0001);
        chk("mr_data", m_rdata, 8'h5A);
        m_req = '0;
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;

        // Fairness: all four hold requests, master i reads slave i
        m_addr = {8'hC0, 8'h80, 8'h40, 8'h00};
        m_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            eo = k % 4;
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                tick();
                if (m_gnt != 0) got = 1'b1;
            end
            chk($sformatf("fair_gnt%0d", k), m_gnt, 32'(1) << eo);
            tick();
            tick();
            chk($sformatf("fair_ack%0d", k), m_ack, 32'(1) << eo);
            chk($sformatf("fair_data%0d", k), m_rdata, SV[eo]);
            tick();
        end
        m_req = '0;
        tick();

        // Three-slave instance: mapped read, then unmapped read of 0xC0
        m_addr3[7:0] = 8'h40; m_req3 = 4'b0001;
        tick();
        chk("um_map_en", s_enable3, 3'b010);
        tick();
        tick();
        chk("um_map_ack", m_ack3, 4'b0001);
        chk("um_map_data", m_rdata3, 8'h22);
        m_req3 = '0;
        tick();
        m_addr3[7:0] = 8'hC0; m_req3 = 4'b0001;
        tick();
        chk("um_en", s_enable3, 0);
`ifdef SBA_ERR_EN
        chk("um_read", s_read3, 0);
`else
        chk("um_read", s_read3, 1);
`endif
        tick();
        tick();
        chk("um_ack", m_ack3, 4'b0001);
        chk("um_data", m_rdata3, 8'h00);
`ifdef SBA_ERR_EN
        chk("um_err", m_err3, 1);
`endif
        m_req3 = '0;
        tick();
`ifdef SBA_ERR_EN
        chk("um_err_clear", m_err3, 0);
`endif
        chk("um_ack_clear", m_ack3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
